// File: rtl/sdfa_cfg_pkg.sv
// rtl/sdfa_cfg_pkg.sv - shared types, default widths and stream-length helper for the SDFA config loader
// Optional macro SDFA_CFG_PARITY_EN appends a trailing even-parity bit to the stream.
package sdfa_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_DISPATCH = 2'd2,
        ST_DONE     = 2'd3
    } sdfa_state_e;

    localparam int DEF_WORD_W    = 28;
    localparam int DEF_NUM_WORDS = 9;
    localparam int DEF_HDR_W     = 3;
    localparam int DEF_IDX_W     = 4;

`ifdef SDFA_CFG_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int sdfa_total_len(input int num_words, input int word_w,
                                          input int hdr_w, input int par_bits);
        return num_words * word_w + hdr_w + par_bits;
    endfunction

endpackage

// File: rtl/sdfa_bit_counter.sv
// rtl/sdfa_bit_counter.sv - up-counter with clear, enable and terminal-count flag
// Wraps to zero when enabled at the terminal value LAST.
module sdfa_bit_counter #(
    parameter int W    = 8,
    parameter int LAST = 255
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    localparam logic [W-1:0] LAST_V = W'(LAST);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST_V) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == LAST_V);

endmodule

// File: rtl/sdfa_cfg_loader.sv
// rtl/sdfa_cfg_loader.sv - serial configuration capture and indexed word dispatch for the SDFA array
// Optional macro SDFA_CFG_PARITY_EN: checks a trailing even-parity bit and reports mismatches on o_err.
module sdfa_cfg_loader
    import sdfa_cfg_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int HDR_W     = DEF_HDR_W,
    parameter int IDX_W     = DEF_IDX_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_start,
    output logic              o_load_req,
    input  logic              i_cfg_valid,
    input  logic              i_cfg_bit,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [IDX_W-1:0]  o_out_idx,
    output logic [WORD_W-1:0] o_out_word,
    output logic [HDR_W-1:0]  o_hdr,
    output logic              o_load_done,
    output logic              o_busy,
    output logic              o_err
);

    localparam int TOTAL      = sdfa_total_len(NUM_WORDS, WORD_W, HDR_W, PARITY_BITS);
    localparam int DATA_BITS  = NUM_WORDS * WORD_W;
    localparam int STORE_BITS = DATA_BITS + HDR_W;
    localparam int BCW        = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    sdfa_state_e             r_state;
    logic                    r_load_req;
    logic                    r_out_valid;
    logic                    r_load_done;
    logic                    r_busy;
    logic [HDR_W-1:0]        r_hdr;
    logic [STORE_BITS-1:0]   r_stream;
    logic [STORE_BITS-1:0]   w_stream_nxt;
    logic [BCW-1:0]          w_bit_cnt;
    logic                    w_bit_tc;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_idx_tc;
    logic                    w_bit_en;
    logic                    w_last_bit;
    logic                    w_hs;
`ifdef SDFA_CFG_PARITY_EN
    logic                    r_par;
    logic                    r_err;
`endif

    // A start pulse masks the same-cycle bit so the first stream bit lands next cycle.
    assign w_bit_en   = (r_state == ST_LOAD) && i_cfg_valid && !i_cfg_start;
    assign w_last_bit = w_bit_en && w_bit_tc;
    assign w_hs       = r_out_valid && i_out_ready;

    sdfa_bit_counter #(.W(BCW), .LAST(TOTAL - 1)) u_bit_cnt (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cfg_start),
        .i_en  (w_bit_en),
        .o_cnt (w_bit_cnt),
        .o_tc  (w_bit_tc)
    );

    sdfa_bit_counter #(.W(IDX_W), .LAST(NUM_WORDS - 1)) u_word_idx (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (i_cfg_start),
        .i_en  (w_hs),
        .o_cnt (w_idx),
        .o_tc  (w_idx_tc)
    );

    // The parity bit itself is never stored; only words and header are kept.
    always_comb begin
        w_stream_nxt = r_stream;
        if (int'(w_bit_cnt) < STORE_BITS) begin
            w_stream_nxt[w_bit_cnt] = i_cfg_bit;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_load_req  <= 1'b0;
            r_out_valid <= 1'b0;
            r_load_done <= 1'b0;
            r_busy      <= 1'b0;
            r_hdr       <= '0;
            r_stream    <= '0;
`ifdef SDFA_CFG_PARITY_EN
            r_par       <= 1'b0;
            r_err       <= 1'b0;
`endif
        end else begin
            if (w_bit_en) begin
                r_stream <= w_stream_nxt;
`ifdef SDFA_CFG_PARITY_EN
                r_par    <= r_par ^ i_cfg_bit;
`endif
            end
            if (i_cfg_start) begin
                r_state     <= ST_LOAD;
                r_load_req  <= 1'b1;
                r_out_valid <= 1'b0;
                r_load_done <= 1'b0;
                r_busy      <= 1'b1;
`ifdef SDFA_CFG_PARITY_EN
                r_par       <= 1'b0;
                r_err       <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_LOAD: begin
                        if (w_last_bit) begin
`ifdef SDFA_CFG_PARITY_EN
                            if (r_par ^ i_cfg_bit) begin
                                r_state    <= ST_IDLE;
                                r_load_req <= 1'b0;
                                r_busy     <= 1'b0;
                                r_err      <= 1'b1;
                            end else
`endif
                            begin
                                r_state     <= ST_DISPATCH;
                                r_load_req  <= 1'b0;
                                r_out_valid <= 1'b1;
                                r_hdr       <= w_stream_nxt[DATA_BITS +: HDR_W];
                            end
                        end
                    end
                    ST_DISPATCH: begin
                        if (w_hs && w_idx_tc) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b0;
                            r_busy      <= 1'b0;
                            r_load_done <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_load_req  = r_load_req;
    assign o_out_valid = r_out_valid;
    assign o_out_idx   = w_idx;
    assign o_out_word  = r_out_valid ? r_stream[int'(w_idx) * WORD_W +: WORD_W] : '0;
    assign o_hdr       = r_hdr;
    assign o_load_done = r_load_done;
    assign o_busy      = r_busy;
`ifdef SDFA_CFG_PARITY_EN
    assign o_err       = r_err;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: doc/sdfa_cfg_loader.md
# sdfa_cfg_loader

Parametrised configuration loader for the SDFA array. Captures a serial configuration bitstream of `NUM_WORDS` words plus a header field, then dispatches the words one at a time to the downstream array over a valid/ready handshake, tagging each word with its index. It generalises the fixed master/block set-up path: one instance per configuration channel, with variable word width and count, downstream backpressure, and restartable reloads.

## Interface
- `WORD_W`, default 28: width of each configuration word.
- `NUM_WORDS`, default 9: number of words per load, range 1..16.
- `HDR_W`, default 3: header width, e.g. the LAYER field.
- `IDX_W`, default 4: width of the word index; must satisfy 2^IDX_W ≥ NUM_WORDS.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `cfg_start` input 1: pulse that begins a new load.
- `load_req` output 1: high while the block is accepting stream bits.
- `cfg_valid` input 1: qualifies `cfg_bit`.
- `cfg_bit` input 1: serial configuration bit.
- `out_valid` output 1: a dispatched word is presented.
- `out_ready` input 1: the downstream side accepts the word.
- `out_idx` output IDX_W: index of the presented word.
- `out_word` output WORD_W: the presented word.
- `hdr` output HDR_W: header of the last completed load.
- `load_done` output 1: all words of the current load have been dispatched.
- `busy` output 1: the block is in LOAD or DISPATCH.
- `err` output 1: sticky parity error flag. Tied to 0 when parity is compiled out.

## Operation
- Stream length: TOTAL = NUM_WORDS*WORD_W + HDR_W, plus 1 when parity is enabled.
- Bit ordering: LSB first. Word 0 bit 0 arrives first. Word k occupies stream bits [k*WORD_W +: WORD_W]. The header occupies the next HDR_W bits, and the parity bit (when enabled) comes last.
- FSM states: IDLE, LOAD, DISPATCH, DONE.
  - IDLE: `cfg_start` moves to LOAD.
  - LOAD: each `cfg_valid` writes the bit at the current bit-counter position and increments the counter. Accepting stream bit TOTAL-1 moves to DISPATCH and captures `hdr`. With parity enabled, a parity mismatch moves to IDLE instead and sets `err`.
  - DISPATCH: `out_valid`=1. Each cycle with `out_valid && out_ready` advances `out_idx`. The handshake on index NUM_WORDS-1 moves to DONE.
  - DONE: `load_done`=1. `cfg_start` moves to LOAD (reload).
- `cfg_start` in any state clears the bit counter, the word index, `load_done` and `err`, then enters LOAD. This also restarts a load or dispatch already in progress. Stale storage contents are not cleared; they are overwritten by the new stream.
- `cfg_valid` outside LOAD is ignored.
- `cfg_valid` in the same cycle as `cfg_start` is ignored. The first bit is taken in the following cycle.
- `load_req` = (state == LOAD).
- `busy` = LOAD or DISPATCH.
- `hdr` updates only on successful completion of a load.

## Timing
- Reset values: every output is 0 and the state is IDLE.
- `load_req` rises the cycle after `cfg_start`.
- The last bit is accepted in cycle t. In cycle t+1, `out_valid`=1 with `out_idx`=0 and `hdr` updated.
- Peak dispatch rate is one word per cycle.
- While `out_valid && !out_ready`, `out_word` and `out_idx` are held stable.
- `load_done` rises the cycle after the final handshake and stays high until `cfg_start` or `rst`.
- `err` rises the cycle after the parity bit is accepted.
- `rst` has priority over `cfg_start`.

## Configuration
- `SDFA_CFG_PARITY_EN` defined: a trailing even-parity bit over all preceding TOTAL-1 bits is required. On mismatch, no words are dispatched, `err` goes to 1 and the FSM returns to IDLE.
- `SDFA_CFG_PARITY_EN` undefined: there is no parity bit, TOTAL excludes it, and `err` is constant 0.

## Structure
- Package `sdfa_cfg_pkg` holds:
  - the FSM state typedef;
  - default width constants;
  - the helper function for the TOTAL length.
- Sub-module `sdfa_bit_counter`: parametrised up-counter with clear, enable and terminal-count output. It is used for both the bit counter and the word index.

## Test plan
- Basic load and dispatch (defaults, TOTAL=255, word k = 28'h0111111*k, hdr=3'b101): with `out_ready`=1, `out_idx` 0..8 are presented in consecutive cycles with matching words, `hdr`=5, and `load_done` rises the cycle after idx 8.
- Backpressure: hold `out_ready`=0 for 5 cycles at idx 3 → idx 3 and its word stay stable, then dispatch resumes. Total handshakes = 9.
- Stream gaps: `cfg_valid` asserted only every third cycle → same words as the basic case, and DISPATCH starts exactly one cycle after the 255th valid bit.
- Restart mid-load: `cfg_start` after 100 bits, then a full new stream → only the words of the new stream are dispatched.
- Restart mid-dispatch: `cfg_start` at idx 4, then a new stream → dispatch begins again from idx 0 with the new data.
- Reset mid-dispatch: `rst` asserted at idx 5 → all outputs 0 next cycle and state IDLE.
- Parity (macro defined): flip the parity bit → `err`=1, `out_valid` never asserted, state IDLE. A following good load clears `err` on `cfg_start`.
